// File: rtl/output_bram_drain_axis_if.sv
// AXI-Stream bundle carrying drained output words.
// master: tdata/tvalid/tlast out, tready in; slave is the mirror.
interface output_bram_drain_axis_if #(
  parameter int DW = 16
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/output_bram_drain_axis.sv
// Drains the 16-bank output BRAM address-major/bank-minor onto AXI-Stream.
// Ports: clk, rst_n, start/base_addr/num_addrs/relu_en, busy/done, ext_read_*, bram_read_data_flat, m_axis.
module output_bram_drain_axis #(
  parameter int DW         = 16,
  parameter int NUM_BRAMS  = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [ADDR_WIDTH:0]             num_addrs,
  input  logic                            relu_en,
  output logic                            busy,
  output logic                            done,
  output logic                            ext_read_mode,
  output logic [NUM_BRAMS*ADDR_WIDTH-1:0] ext_read_addr_flat,
  output logic [NUM_BRAMS-1:0]            ext_read_en,
  input  logic [NUM_BRAMS*DW-1:0]         bram_read_data_flat,
  output_bram_drain_axis_if.master        m_axis
);
  localparam int IW = $clog2(NUM_BRAMS);
  localparam logic [IW-1:0] IDX_ONE = 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_BRAMS - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    SEND,
    FINISH
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   num_q;
  logic [ADDR_WIDTH:0]   addr_cnt;
  logic                  relu_q;
  logic [IW-1:0]         word_idx;
  logic [DW-1:0]         buf_q [NUM_BRAMS];
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  last_word;
  logic                  last_addr;
  logic                  beat;
  logic                  accept;

  function automatic logic [DW-1:0] relu(
    input logic          en,
    input logic [DW-1:0] w
  );
    return (en && w[DW-1]) ? '0 : w;
  endfunction

  assign last_word = word_idx == IDX_LAST;
  assign last_addr = (addr_cnt + CNT_ONE) == num_q;
  assign beat      = m_axis.tvalid & m_axis.tready;
  assign accept    = (state == IDLE) && start && (num_addrs != '0);

  // Address is only updated on transitions into READ, so it stays
  // stable for the rest of each address period.
  assign rd_addr = base_q + addr_cnt[ADDR_WIDTH-1:0];
  assign ext_read_addr_flat = {NUM_BRAMS{rd_addr}};
  assign m_axis.tdata = buf_q[word_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    busy          = 1'b0;
    ext_read_mode = 1'b0;
    ext_read_en   = '0;
    m_axis.tvalid = 1'b0;
    m_axis.tlast  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (num_addrs != '0) ? READ : FINISH;
      end
      READ: begin
        busy          = 1'b1;
        ext_read_mode = 1'b1;
        ext_read_en   = '1;
        state_nx      = CAPTURE;
      end
      CAPTURE: begin
        busy          = 1'b1;
        ext_read_mode = 1'b1;
        state_nx      = SEND;
      end
      SEND: begin
        busy          = 1'b1;
        ext_read_mode = 1'b1;
        m_axis.tvalid = 1'b1;
        m_axis.tlast  = last_word && last_addr;
        if (beat && last_word)
          state_nx = last_addr ? FINISH : READ;
      end
      FINISH: begin
        busy          = 1'b1;
        ext_read_mode = 1'b1;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      num_q    <= '0;
      relu_q   <= 1'b0;
      addr_cnt <= '0;
      word_idx <= '0;
      done     <= 1'b0;
      for (int b = 0; b < NUM_BRAMS; b++)
        buf_q[b] <= '0;
    end else begin
      // done lands in the first IDLE cycle, together with the port release.
      done <= state == FINISH;
      if (accept) begin
        base_q   <= base_addr;
        num_q    <= num_addrs;
        relu_q   <= relu_en;
        addr_cnt <= '0;
      end
      if (state == CAPTURE) begin
        word_idx <= '0;
        for (int b = 0; b < NUM_BRAMS; b++)
          buf_q[b] <= relu(relu_q, bram_read_data_flat[b*DW +: DW]);
      end
      if (state == SEND && beat) begin
        word_idx <= word_idx + IDX_ONE;
        if (last_word && !last_addr)
          addr_cnt <= addr_cnt + CNT_ONE;
      end
    end
  end
endmodule

// File: tb/tb_output_bram_drain_axis.sv
// Table-driven bench for output_bram_drain_axis with a BRAM model.
// Checks order, wrap, ReLU, stalls, done timing, busy-start and reset abort.
module tb_output_bram_drain_axis;
  localparam int DW = 16;
  localparam int NB = 16;
  localparam int AW = 9;
  localparam int DEPTH = 512;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [AW:0]       num_addrs;
  logic              relu_en;
  logic              busy;
  logic              done;
  logic              ext_read_mode;
  logic [NB*AW-1:0]  ext_read_addr_flat;
  logic [NB-1:0]     ext_read_en;
  logic [NB*DW-1:0]  bram_read_data_flat = '0;

  output_bram_drain_axis_if #(.DW(DW)) axis ();

  output_bram_drain_axis #(
    .DW(DW),
    .NUM_BRAMS(NB),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .base_addr(base_addr),
    .num_addrs(num_addrs),
    .relu_en(relu_en),
    .busy(busy),
    .done(done),
    .ext_read_mode(ext_read_mode),
    .ext_read_addr_flat(ext_read_addr_flat),
    .ext_read_en(ext_read_en),
    .bram_read_data_flat(bram_read_data_flat),
    .m_axis(axis)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [NB][DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (ext_read_en[b])
        bram_read_data_flat[b*DW +: DW] <= mem[b][ext_read_addr_flat[b*AW +: AW]];
  end

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   num;
    logic          relu;
    logic          rnd;
    logic          inj;
    int            exp_beats;
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_last;
    int            exp_done;
  } vec_t;

  vec_t vecs [6];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input int bank, input int addr,
                                          input logic relu);
    logic [DW-1:0] v;
    v = mem[bank][addr];
    return (relu && v[DW-1]) ? '0 : v;
  endfunction

  task automatic run_drain(input vec_t v);
    int beats = 0;
    int reads = 0;
    int done_cyc = -1;
    int ea;
    logic stalled = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic hold_l = 1'b0;
    logic [DW-1:0] first_d = '0;
    logic [DW-1:0] last_d = '0;
    @(negedge clk);
    base_addr = v.base;
    num_addrs = v.num;
    relu_en   = v.relu;
    start     = 1'b1;
    axis.tready = 1'b1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (v.inj && cyc == 5) begin
        start     = 1'b1;
        base_addr = 9'd200;
        num_addrs = 10'd7;
        relu_en   = 1'b1;
      end
      if (cyc == 1)
        check("busy_after_start", {31'b0, busy}, 1);
      if (stalled) begin
        check("stall_tvalid", {31'b0, axis.tvalid}, 1);
        check("stall_tdata", {16'b0, axis.tdata}, {16'b0, hold_d});
        check("stall_tlast", {31'b0, axis.tlast}, {31'b0, hold_l});
      end
      if (ext_read_en != '0) begin
        ea = (int'(v.base) + reads) % DEPTH;
        check("rd_en", {16'b0, ext_read_en}, 32'hFFFF);
        check("rd_mode", {31'b0, ext_read_mode}, 1);
        check("rd_addr_bcast",
              {31'b0, ext_read_addr_flat == {NB{ea[AW-1:0]}}}, 1);
        reads++;
      end
      if (done) begin
        done_cyc = cyc;
        check("done_busy", {31'b0, busy}, 0);
        check("done_mode", {31'b0, ext_read_mode}, 0);
        break;
      end
      axis.tready = v.rnd ? ($urandom_range(0, 99) >= 40) : 1'b1;
      if (axis.tvalid) begin
        if (axis.tready) begin
          ea = (int'(v.base) + beats / NB) % DEPTH;
          check("beat_data", {16'b0, axis.tdata},
                {16'b0, model(beats % NB, ea, v.relu)});
          check("beat_tlast", {31'b0, axis.tlast},
                {31'b0, beats == v.exp_beats - 1});
          if (beats == 0) first_d = axis.tdata;
          last_d = axis.tdata;
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hold_d  = axis.tdata;
          hold_l  = axis.tlast;
        end
      end else begin
        stalled = 1'b0;
      end
    end
    check("done_seen", {31'b0, done_cyc > 0}, 1);
    check("beat_count", beats, v.exp_beats);
    check("read_count", reads, {22'b0, v.num});
    if (v.exp_done > 0)
      check("done_cycle", done_cyc, v.exp_done);
    if (v.exp_beats > 0) begin
      check("first_word", {16'b0, first_d}, {16'b0, v.exp_first});
      check("last_word", {16'b0, last_d}, {16'b0, v.exp_last});
    end
    @(negedge clk);
    check("done_one_pulse", {31'b0, done}, 0);
    check("idle_tvalid", {31'b0, axis.tvalid}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    num_addrs = '0;
    relu_en = 1'b0;
    axis.tready = 1'b0;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++)
        mem[b][a] = DW'((b << 8) | a);
    for (int b = 0; b < NB; b++)
      mem[b][100] = (b % 2 == 0) ? 16'hFFF0 : 16'h0005;

    vecs[0] = '{9'd0,   10'd2, 1'b0, 1'b0, 1'b1, 32, 16'h0000, 16'h0F01, 38};
    vecs[1] = '{9'd5,   10'd3, 1'b0, 1'b1, 1'b0, 48, 16'h0005, 16'h0F07, 0};
    vecs[2] = '{9'd510, 10'd4, 1'b0, 1'b0, 1'b0, 64, 16'h01FE, 16'h0F01, 74};
    vecs[3] = '{9'd100, 10'd1, 1'b1, 1'b0, 1'b0, 16, 16'h0000, 16'h0005, 20};
    vecs[4] = '{9'd100, 10'd1, 1'b0, 1'b0, 1'b0, 16, 16'hFFF0, 16'h0005, 20};
    vecs[5] = '{9'd3,   10'd0, 1'b0, 1'b0, 1'b0, 0,  16'h0000, 16'h0000, 2};

    #12;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_mode", {31'b0, ext_read_mode}, 0);
    check("rst_en", {16'b0, ext_read_en}, 0);
    check("rst_tvalid", {31'b0, axis.tvalid}, 0);
    check("rst_tlast", {31'b0, axis.tlast}, 0);
    check("rst_tdata", {16'b0, axis.tdata}, 0);
    check("rst_addr", {31'b0, ext_read_addr_flat == '0}, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_drain(vecs[i]);

    // Abort a drain mid-SEND with an asynchronous reset.
    @(negedge clk);
    base_addr = 9'd0;
    num_addrs = 10'd2;
    relu_en = 1'b0;
    axis.tready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int seen = 0;
      for (int cyc = 0; cyc < 200 && seen < 20; cyc++) begin
        if (axis.tvalid) seen++;
        @(negedge clk);
      end
      check("pre_reset_beats", seen, 20);
    end
    check("pre_reset_tvalid", {31'b0, axis.tvalid}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tvalid", {31'b0, axis.tvalid}, 0);
    check("arst_tlast", {31'b0, axis.tlast}, 0);
    check("arst_busy", {31'b0, busy}, 0);
    check("arst_mode", {31'b0, ext_read_mode}, 0);
    check("arst_en", {16'b0, ext_read_en}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_drain(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
